// File: rtl/neuron_pkg.sv
// Shared width defaults, FSM encoding and neuron control bundle for the neuron feeder.
package neuron_pkg;

  localparam int unsigned W_WEIGHT_DEF     = 32;
  localparam int unsigned W_PIXEL_DATA_DEF = 8;
  localparam int unsigned W_RESULT_DEF     = 32;
  localparam int unsigned W_BIAS_DEF       = 32;
  localparam int unsigned N_INPUTS_DEF     = 784;
  localparam int unsigned W_ADDR_DEF       = 10;
  localparam int unsigned W_STATE          = 3;

  typedef enum logic [W_STATE-1:0] {
    ST_IDLE   = W_STATE'(0),
    ST_BIAS   = W_STATE'(1),
    ST_STREAM = W_STATE'(2),
    ST_DRAIN  = W_STATE'(3),
    ST_RESULT = W_STATE'(4)
  } state_e;

  typedef struct packed {
    logic clear;
    logic set_bias;
    logic active;
  } neuron_ctrl_t;

  // Neuron strobes implied by a state; clear is owned by the abort path.
  function automatic neuron_ctrl_t ctrl_for(input state_e st);
    neuron_ctrl_t c;
    c          = '0;
    c.set_bias = (st == ST_BIAS);
    c.active   = (st == ST_STREAM) || (st == ST_DRAIN);
    return c;
  endfunction

endpackage

// File: rtl/neuron_feeder_if.sv
// Memory read port, neuron datapath controls and result handshake of the neuron feeder.
interface neuron_feeder_if
  import neuron_pkg::*;
#(
  parameter int unsigned W_WEIGHT     = W_WEIGHT_DEF,
  parameter int unsigned W_PIXEL_DATA = W_PIXEL_DATA_DEF,
  parameter int unsigned W_RESULT     = W_RESULT_DEF,
  parameter int unsigned W_BIAS       = W_BIAS_DEF,
  parameter int unsigned W_ADDR       = W_ADDR_DEF
) ();

  logic                    rd_en;
  logic [W_ADDR-1:0]       rd_addr;
  logic [W_PIXEL_DATA-1:0] pix_rd_data;
  logic [W_WEIGHT-1:0]     wgt_rd_data;
  logic                    n_clear;
  logic                    n_set_bias;
  logic                    n_active;
  logic [W_BIAS-1:0]       n_bias;
  logic [W_PIXEL_DATA-1:0] n_pixel;
  logic [W_WEIGHT-1:0]     n_weight;
  logic [W_RESULT-1:0]     n_sigma;
  logic                    res_valid;
  logic                    res_ready;
  logic [W_RESULT-1:0]     res_data;

  modport master (
    output rd_en, rd_addr,
    input  pix_rd_data, wgt_rd_data,
    output n_clear, n_set_bias, n_active, n_bias, n_pixel, n_weight,
    input  n_sigma,
    output res_valid, res_data,
    input  res_ready
  );

  modport slave (
    input  rd_en, rd_addr,
    output pix_rd_data, wgt_rd_data,
    input  n_clear, n_set_bias, n_active, n_bias, n_pixel, n_weight,
    output n_sigma,
    input  res_valid, res_data,
    output res_ready
  );

endinterface

// File: rtl/neuron_relu.sv
// Optional ReLU on the accumulator: negative values clamp to zero when enabled.
module neuron_relu
  import neuron_pkg::*;
#(
  parameter int unsigned W_RESULT = W_RESULT_DEF
) (
  input  logic                relu_en_i,
  input  logic [W_RESULT-1:0] sigma_i,
  output logic [W_RESULT-1:0] data_c_o
);

  assign data_c_o = (relu_en_i && sigma_i[W_RESULT-1]) ? '0 : sigma_i;

endmodule

// File: rtl/neuron_feeder.sv
// Sequences one dot product: bias load, operand streaming over the shared read port,
// drain of the last element, then a held result until it is accepted.
module neuron_feeder
  import neuron_pkg::*;
#(
  parameter int unsigned W_WEIGHT     = W_WEIGHT_DEF,
  parameter int unsigned W_PIXEL_DATA = W_PIXEL_DATA_DEF,
  parameter int unsigned W_RESULT     = W_RESULT_DEF,
  parameter int unsigned W_BIAS       = W_BIAS_DEF,
  parameter int unsigned N_INPUTS     = N_INPUTS_DEF,
  parameter int unsigned W_ADDR       = W_ADDR_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic              relu_en,
  input  logic [W_BIAS-1:0] bias_in,
  output logic              busy,
  neuron_feeder_if.master   bus
);

  localparam logic [W_ADDR-1:0] LAST_ADDR = W_ADDR'(N_INPUTS - 1);

  state_e                  state_q, state_d;
  logic [W_ADDR-1:0]       addr_q, addr_d;
  logic [W_BIAS-1:0]       bias_q, bias_d;
  neuron_ctrl_t            ctrl_q, ctrl_d;
  logic                    rd_en_q, rd_en_d;
  logic                    busy_q, busy_d;
  logic                    valid_q, valid_d;
  logic                    abort_hit;
  logic                    accept;
  logic [W_PIXEL_DATA-1:0] pix_c;
  logic [W_WEIGHT-1:0]     wgt_c;
  logic [W_RESULT-1:0]     clamp_c;

  assign abort_hit = abort && (state_q != ST_IDLE);
  assign accept    = (state_q == ST_RESULT) && bus.res_ready;

  // Next state, address and registered-output values; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    bias_d  = bias_q;
    addr_d  = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_BIAS;
          bias_d  = bias_in;
        end
      end
      ST_BIAS: begin
        if (N_INPUTS > 1) state_d = ST_STREAM;
        else              state_d = ST_DRAIN;
      end
      ST_STREAM: begin
        if (addr_q == LAST_ADDR) state_d = ST_DRAIN;
      end
      ST_DRAIN:  state_d = ST_RESULT;
      ST_RESULT: begin
        if (accept) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;

    // Address stays below LAST_ADDR + 1 because STREAM exits on issuing LAST_ADDR.
    if (state_d == ST_STREAM) addr_d = addr_q + W_ADDR'(1);

    ctrl_d       = ctrl_for(state_d);
    ctrl_d.clear = abort_hit;
    rd_en_d      = (state_d == ST_BIAS) || (state_d == ST_STREAM);
    busy_d       = (state_d != ST_IDLE);
    valid_d      = (state_d == ST_RESULT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      bias_q  <= '0;
      ctrl_q  <= '0;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bias_q  <= bias_d;
      ctrl_q  <= ctrl_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  neuron_relu #(
    .W_RESULT (W_RESULT)
  ) u_relu (
    .relu_en_i (relu_en),
    .sigma_i   (bus.n_sigma),
    .data_c_o  (clamp_c)
  );

  // Memory data passes straight to the neuron; it already arrives one cycle after rd_en.
  assign pix_c = bus.pix_rd_data;
  assign wgt_c = bus.wgt_rd_data;

  assign busy           = busy_q;
  assign bus.rd_en      = rd_en_q;
  assign bus.rd_addr    = addr_q;
  assign bus.n_clear    = ctrl_q.clear;
  assign bus.n_set_bias = ctrl_q.set_bias;
  assign bus.n_active   = ctrl_q.active;
  assign bus.n_bias     = bias_q;
  assign bus.n_pixel    = pix_c;
  assign bus.n_weight   = wgt_c;
  assign bus.res_valid  = valid_q;
  // The neuron accumulator is registered and frozen in RESULT, so the gated clamp is stable.
  assign bus.res_data   = valid_q ? clamp_c : '0;

endmodule

// File: tb/tb_neuron_feeder.sv
// Directed bench for neuron_feeder: N_INPUTS=4 and N_INPUTS=1 instances with a behavioural
// memory and accumulating neuron around each.
`timescale 1ns/1ps
module tb_neuron_feeder;

  localparam int unsigned WW = 32;
  localparam int unsigned WP = 8;
  localparam int unsigned WR = 32;
  localparam int unsigned WB = 32;
  localparam int unsigned WA = 10;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic          start4, abort4, relu4, busy4;
  logic [WB-1:0] bias4;
  logic          start1, abort1, relu1, busy1;
  logic [WB-1:0] bias1;

  logic [WP-1:0] pix4 [4];
  logic [WW-1:0] wgt4 [4];
  logic [WP-1:0] pix1;
  logic [WW-1:0] wgt1;

  neuron_feeder_if #(.W_WEIGHT(WW), .W_PIXEL_DATA(WP), .W_RESULT(WR), .W_BIAS(WB), .W_ADDR(WA)) bus4 ();
  neuron_feeder_if #(.W_WEIGHT(WW), .W_PIXEL_DATA(WP), .W_RESULT(WR), .W_BIAS(WB), .W_ADDR(WA)) bus1 ();

  neuron_feeder #(
    .W_WEIGHT(WW), .W_PIXEL_DATA(WP), .W_RESULT(WR), .W_BIAS(WB), .N_INPUTS(4), .W_ADDR(WA)
  ) u_dut4 (
    .clk(clk), .rstn(rstn), .start(start4), .abort(abort4), .relu_en(relu4),
    .bias_in(bias4), .busy(busy4), .bus(bus4)
  );

  neuron_feeder #(
    .W_WEIGHT(WW), .W_PIXEL_DATA(WP), .W_RESULT(WR), .W_BIAS(WB), .N_INPUTS(1), .W_ADDR(WA)
  ) u_dut1 (
    .clk(clk), .rstn(rstn), .start(start1), .abort(abort1), .relu_en(relu1),
    .bias_in(bias1), .busy(busy1), .bus(bus1)
  );

  function automatic logic [31:0] mac(input logic [31:0] acc, input logic [7:0] pix,
                                      input logic [31:0] wgt);
    logic signed [31:0] prod;
    prod = $signed({24'd0, pix}) * $signed(wgt);
    return acc + prod;
  endfunction

  // Synchronous-read memories and neuron models
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bus4.pix_rd_data <= '0; bus4.wgt_rd_data <= '0; bus4.n_sigma <= '0;
      bus1.pix_rd_data <= '0; bus1.wgt_rd_data <= '0; bus1.n_sigma <= '0;
    end else begin
      if (bus4.rd_en) begin
        bus4.pix_rd_data <= pix4[bus4.rd_addr[1:0]];
        bus4.wgt_rd_data <= wgt4[bus4.rd_addr[1:0]];
      end
      if (bus1.rd_en) begin
        bus1.pix_rd_data <= pix1;
        bus1.wgt_rd_data <= wgt1;
      end
      if (bus4.n_clear)         bus4.n_sigma <= '0;
      else if (bus4.n_set_bias) bus4.n_sigma <= bus4.n_bias;
      else if (bus4.n_active)   bus4.n_sigma <= mac(bus4.n_sigma, bus4.n_pixel, bus4.n_weight);
      if (bus1.n_clear)         bus1.n_sigma <= '0;
      else if (bus1.n_set_bias) bus1.n_sigma <= bus1.n_bias;
      else if (bus1.n_active)   bus1.n_sigma <= mac(bus1.n_sigma, bus1.n_pixel, bus1.n_weight);
    end
  end

  int act4 = 0, vld4 = 0, overlap = 0;
  always @(posedge clk) begin
    if (bus4.n_active)  act4 = act4 + 1;
    if (bus4.res_valid) vld4 = vld4 + 1;
    if ((int'(bus4.n_clear) + int'(bus4.n_set_bias) + int'(bus4.n_active)) > 1) overlap = overlap + 1;
    if ((int'(bus1.n_clear) + int'(bus1.n_set_bias) + int'(bus1.n_active)) > 1) overlap = overlap + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle4(input string tag);
    check({tag, "_ctrl"}, 64'({busy4, bus4.rd_en, bus4.n_clear, bus4.n_set_bias,
                               bus4.n_active, bus4.res_valid}), 64'(0));
    check({tag, "_addr"},  64'(bus4.rd_addr),  64'(0));
    check({tag, "_nbias"}, 64'(bus4.n_bias),   64'(0));
    check({tag, "_data"},  64'(bus4.res_data), 64'(0));
  endtask

  // Start pulse, then check each phase; returns in the first RESULT cycle (cycle 6).
  task automatic run4(input logic [WB-1:0] bias, input logic relu);
    bias4 = bias; relu4 = relu; start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    check("bias_phase", 64'({bus4.n_set_bias, bus4.rd_en, bus4.n_active}), 64'(3'b110));
    check("bias_addr",  64'(bus4.rd_addr), 64'(0));
    check("bias_value", 64'(bus4.n_bias),  64'(bias));
    for (int k = 1; k < 4; k++) begin
      tick(1);
      check("stream_addr", 64'(bus4.rd_addr), 64'(k));
      check("stream_ctrl", 64'({bus4.rd_en, bus4.n_active, bus4.n_set_bias}), 64'(3'b110));
    end
    tick(1);
    check("drain_ctrl", 64'({bus4.rd_en, bus4.n_active, bus4.res_valid}), 64'(3'b010));
    tick(1);
    check("result_valid", 64'({bus4.res_valid, busy4, bus4.n_active}), 64'(3'b110));
  endtask

  task automatic accept4();
    bus4.res_ready = 1'b1;
    tick(1);
    bus4.res_ready = 1'b0;
    check("accept_idle", 64'({busy4, bus4.res_valid}), 64'(0));
  endtask

  int base;

  initial begin
    rstn = 1'b0;
    start4 = 1'b0; abort4 = 1'b0; relu4 = 1'b0; bias4 = '0; bus4.res_ready = 1'b0;
    start1 = 1'b0; abort1 = 1'b0; relu1 = 1'b0; bias1 = '0; bus1.res_ready = 1'b0;
    pix4 = '{8'd1, 8'd2, 8'd3, 8'd4};
    wgt4 = '{32'd1, 32'd1, 32'd1, 32'd1};
    pix1 = 8'd3; wgt1 = 32'd7;
    tick(2);
    check_idle4("reset");
    check("reset_n1", 64'({busy1, bus1.rd_en, bus1.n_set_bias, bus1.n_active, bus1.res_valid}), 64'(0));
    rstn = 1'b1;
    tick(1);

    // Basic dot product, relu enabled on a positive result
    base = act4;
    run4(32'd10, 1'b1);
    check("basic_data", 64'(bus4.res_data), 64'(20));
    check("basic_active_count", 64'(act4 - base), 64'(4));
    accept4();

    // Negative sum with and without ReLU
    pix4 = '{8'd1, 8'd1, 8'd1, 8'd1};
    wgt4 = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    run4(32'd0, 1'b1);
    check("relu_clamp", 64'(bus4.res_data), 64'(0));
    accept4();
    run4(32'd0, 1'b0);
    check("relu_off", 64'(bus4.res_data), 64'(32'hFFFF_FFFB));
    accept4();

    // Backpressure: result held, no streaming, second start ignored
    pix4 = '{8'd2, 8'd2, 8'd2, 8'd2};
    wgt4 = '{32'd3, 32'd3, 32'd3, 32'd3};
    run4(32'd5, 1'b0);
    base = act4;
    start4 = 1'b1; bias4 = 32'd99;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("stall_valid", 64'(bus4.res_valid), 64'(1));
      check("stall_data",  64'(bus4.res_data),  64'(29));
    end
    check("stall_no_active", 64'(act4 - base), 64'(0));
    start4 = 1'b0;
    accept4();
    tick(1);
    check("stall_start_dropped", 64'(busy4), 64'(0));

    // Ready already high on RESULT entry, start in the same cycle ignored
    pix4 = '{8'd1, 8'd2, 8'd3, 8'd4};
    wgt4 = '{32'd1, 32'd1, 32'd1, 32'd1};
    bus4.res_ready = 1'b1;
    run4(32'd0, 1'b0);
    check("entry_data", 64'(bus4.res_data), 64'(10));
    start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    check("entry_accept", 64'({busy4, bus4.res_valid}), 64'(0));
    tick(1);
    bus4.res_ready = 1'b0;
    check("entry_start_ignored", 64'(busy4), 64'(0));

    // Abort in IDLE is ignored
    abort4 = 1'b1;
    tick(1);
    abort4 = 1'b0;
    check("idle_abort", 64'({bus4.n_clear, busy4}), 64'(0));

    // Abort mid-STREAM at address 2
    bias4 = 32'd7; start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    tick(2);
    check("abort_at_addr", 64'(bus4.rd_addr), 64'(2));
    abort4 = 1'b1;
    base = vld4;
    tick(1);
    abort4 = 1'b0;
    check("abort_clear", 64'({bus4.n_clear, busy4, bus4.rd_en, bus4.n_active, bus4.res_valid}),
          64'(5'b10000));
    tick(1);
    check("abort_clear_once", 64'(bus4.n_clear), 64'(0));
    check("abort_sigma", 64'(bus4.n_sigma), 64'(0));
    tick(8);
    check("abort_no_result", 64'(vld4 - base), 64'(0));
    run4(32'hFFFF_FFFD, 1'b0);
    check("after_abort_data", 64'(bus4.res_data), 64'(7));
    accept4();

    // Single-element configuration: BIAS -> DRAIN -> RESULT
    bias1 = 32'd1; start1 = 1'b1;
    tick(1);
    start1 = 1'b0;
    check("n1_bias", 64'({bus1.n_set_bias, bus1.rd_en, bus1.n_active}), 64'(3'b110));
    check("n1_addr", 64'(bus1.rd_addr), 64'(0));
    tick(1);
    check("n1_drain", 64'({bus1.rd_en, bus1.n_active, bus1.res_valid}), 64'(3'b010));
    tick(1);
    check("n1_valid", 64'({bus1.res_valid, busy1}), 64'(2'b11));
    check("n1_data", 64'(bus1.res_data), 64'(22));
    bus1.res_ready = 1'b1;
    tick(1);
    bus1.res_ready = 1'b0;
    check("n1_accept", 64'({busy1, bus1.res_valid}), 64'(0));

    // Reset mid-STREAM discards the operation
    bias4 = 32'd10; start4 = 1'b1;
    tick(1);
    start4 = 1'b0;
    tick(2);
    rstn = 1'b0;
    #1;
    check_idle4("midrst");
    tick(1);
    rstn = 1'b1;
    base = vld4;
    tick(10);
    check("midrst_no_result", 64'(vld4 - base), 64'(0));
    check("midrst_idle", 64'(busy4), 64'(0));

    check("ctrl_exclusive", 64'(overlap), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
